// File: rtl/dsi_pkg.sv
// DSI receive-path package: data-type constants, long/short classification,
// parser FSM states and the Hamming parity masks shared with the assembler.
package dsi_pkg;

  localparam logic [5:0] DT_VSS        = 6'h01;
  localparam logic [5:0] DT_HSS        = 6'h21;
  localparam logic [5:0] DT_BLANK      = 6'h19;
  localparam logic [5:0] DT_RGB888     = 6'h3E;
  localparam logic [5:0] DT_DCS_SHORT0 = 6'h05;
  localparam logic [5:0] DT_DCS_SHORT1 = 6'h15;
  localparam logic [5:0] DT_DCS_LONG   = 6'h39;

  typedef enum logic [1:0] {
    S_HDR,
    S_PAY,
    S_CRC,
    S_DISCARD
  } parser_state_t;

  // Parity masks over header bits [31:8] (mask bit i = header bit 8+i).
  // Index p gives ECC bit p; ECC[7:6] are always zero.
  localparam logic [5:0][23:0] ECC_MASKS = {
    24'hEFFC00,  // P5
    24'hDF03F0,  // P4
    24'hB8E38E,  // P3
    24'h749A6D,  // P2
    24'hF2555B,  // P1
    24'hF12CB7   // P0
  };

  function automatic logic [5:0] ecc_parity(input logic [23:0] d);
    logic [5:0] par;
    par = '0;
    for (int p = 0; p < 6; p++) begin
      par[p] = ^(d & ECC_MASKS[p]);
    end
    return par;
  endfunction

  function automatic logic is_long_dt(input logic [5:0] dt);
    case (dt)
      6'h09, 6'h19, 6'h29, 6'h39,
      6'h0C, 6'h1C, 6'h2C,
      6'h0D, 6'h1D, 6'h3D,
      6'h0E, 6'h1E, 6'h2E, 6'h3E: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  // Byte count (0..4) to a low-aligned byte strobe.
  function automatic logic [3:0] bytes_to_strb(input logic [2:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/packets_parser_if.sv
// Received word stream from the lanes receiver into the packet parser.
interface packets_parser_if;
  logic [31:0] iface_read_data;
  logic [3:0]  iface_read_strb;
  logic        iface_read_valid;
  logic        iface_last_word;

  modport master (
    output iface_read_data,
    output iface_read_strb,
    output iface_read_valid,
    output iface_last_word
  );

  modport slave (
    input iface_read_data,
    input iface_read_strb,
    input iface_read_valid,
    input iface_last_word
  );
endinterface

// File: rtl/crc_calculator.sv
// CRC-16/CCITT, reflected (poly 0x8408), init 0xFFFF, no final xor.
// Consumes up to four bytes per valid cycle, byte0 first, per strobe bit.
// Only compiled into builds with DSI_PARSER_CRC_CHECK_EN.
`ifdef DSI_PARSER_CRC_CHECK_EN
module crc_calculator (
  input  logic        clk,
  input  logic        srst,
  input  logic        init,
  input  logic [31:0] data,
  input  logic [3:0]  strb,
  input  logic        valid,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;
  logic [15:0] crc_next;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Fold the strobed bytes of this word into the running CRC.
  always_comb begin
    crc_next = crc_reg;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) crc_next = crc_byte(crc_next, data[8*k +: 8]);
    end
  end

  // Running CRC register, restarted on reset or at each new header.
  always_ff @(posedge clk) begin
    if (srst || init) crc_reg <= 16'hFFFF;
    else if (valid)   crc_reg <= crc_next;
  end

  assign crc = crc_reg;

endmodule
`endif

// File: rtl/ecc_decoder.sv
// Combinational DSI header ECC check/correct (SEC-DED).
// A syndrome matching a data column flips that bit; a one-hot syndrome is a
// parity-bit error (data already good); anything else nonzero is fatal.
module ecc_decoder
  import dsi_pkg::*;
(
  input  logic [31:0] hdr_word,
  output logic [23:0] data_corrected,
  output logic        corrected,
  output logic        fatal
);

  logic [23:0] data_rx;
  logic [7:0]  syndrome;
  logic [23:0] flip;

  assign data_rx  = hdr_word[31:8];
  assign syndrome = {2'b00, ecc_parity(data_rx)} ^ hdr_word[7:0];

  // One comparator per data bit against its parity column.
  generate
    for (genvar gi = 0; gi < 24; gi++) begin : g_col
      assign flip[gi] = (syndrome == {2'b00, ECC_MASKS[5][gi], ECC_MASKS[4][gi],
                                      ECC_MASKS[3][gi], ECC_MASKS[2][gi],
                                      ECC_MASKS[1][gi], ECC_MASKS[0][gi]});
    end
  endgenerate

  assign data_corrected = data_rx ^ flip;
  assign corrected      = (|flip) || $onehot(syndrome);
  assign fatal          = (syndrome != 8'h00) && !corrected;

endmodule

// File: rtl/packets_parser.sv
// DSI packet parser: splits the received HS word stream into packets,
// ECC-corrects headers, checks long-packet CRC and streams payload out.
// Build option: DSI_PARSER_CRC_CHECK_EN enables the CRC engine; without it
// the CRC word is consumed and ignored and err_crc stays 0.
module packets_parser
  import dsi_pkg::*;
#(
  parameter int WC_WIDTH      = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_sys,
  packets_parser_if.slave          rx,
  output logic                     hdr_valid,
  output logic [1:0]               hdr_vc,
  output logic [5:0]               hdr_dt,
  output logic [15:0]              hdr_wc,
  output logic                     hdr_long,
  output logic [31:0]              payload_data,
  output logic [3:0]               payload_strb,
  output logic                     payload_valid,
  output logic                     payload_last,
  output logic                     pkt_done,
  output logic                     err_ecc_corrected,
  output logic                     err_ecc_fatal,
  output logic                     err_crc,
  output logic                     err_truncated,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_ecc,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_crc
);

  parser_state_t state_reg, state_next;
  logic [WC_WIDTH-1:0] remaining_reg, remaining_next;

  logic        hdr_valid_reg, hdr_valid_next;
  logic [1:0]  hdr_vc_reg, hdr_vc_next;
  logic [5:0]  hdr_dt_reg, hdr_dt_next;
  logic [15:0] hdr_wc_reg, hdr_wc_next;
  logic        hdr_long_reg, hdr_long_next;
  logic [31:0] payload_data_reg, payload_data_next;
  logic [3:0]  payload_strb_reg, payload_strb_next;
  logic        payload_valid_reg, payload_valid_next;
  logic        payload_last_reg, payload_last_next;
  logic        pkt_done_reg, pkt_done_next;
  logic        ecc_corr_reg, ecc_corr_next;
  logic        ecc_fatal_reg, ecc_fatal_next;
  logic        crc_err_reg, crc_err_next;
  logic        trunc_reg, trunc_next;
  logic [ERR_CNT_WIDTH-1:0] cnt_ecc_reg, cnt_ecc_next;
  logic [ERR_CNT_WIDTH-1:0] cnt_crc_reg, cnt_crc_next;

  logic        word_in, last_in, strb_ok;
  logic [23:0] hdr_fixed;
  logic        ecc_corr, ecc_fatal;
  logic        long_w, wc_zero;
  logic [2:0]  take_bytes;
  logic [3:0]  take_strb;
  logic [31:0] take_mask;
  logic [31:0] pay_data_w;
  logic        pay_last_w;
  logic        crc_mismatch;

  assign word_in = rx.iface_read_valid;
  assign last_in = rx.iface_read_valid && rx.iface_last_word;
  assign strb_ok = (rx.iface_read_strb == 4'hF);

  ecc_decoder u_ecc (
    .hdr_word       (rx.iface_read_data),
    .data_corrected (hdr_fixed),
    .corrected      (ecc_corr),
    .fatal          (ecc_fatal)
  );

  assign long_w  = is_long_dt(hdr_fixed[21:16]);
  assign wc_zero = (hdr_fixed[15:0] == 16'h0000);

  // Bytes taken from the current payload word: min(4, remaining).
  assign take_bytes = (remaining_reg >= WC_WIDTH'(4)) ? 3'd4 : remaining_reg[2:0];
  assign take_strb  = bytes_to_strb(take_bytes);
  assign pay_last_w = (remaining_reg <= WC_WIDTH'(4));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign take_mask[8*gi +: 8] = {8{take_strb[gi]}};
    end
  endgenerate

  assign pay_data_w = rx.iface_read_data & take_mask;

`ifdef DSI_PARSER_CRC_CHECK_EN
  logic [15:0] crc_value;
  logic        crc_init;
  logic        crc_feed;

  assign crc_init = (state_reg == S_HDR) && word_in;
  assign crc_feed = (state_reg == S_PAY) && word_in;

  crc_calculator u_crc (
    .clk   (clk_sys),
    .srst  (rst_sys),
    .init  (crc_init),
    .data  (pay_data_w),
    .strb  (take_strb),
    .valid (crc_feed),
    .crc   (crc_value)
  );

  assign crc_mismatch = (rx.iface_read_data[15:0] != crc_value);
`else
  assign crc_mismatch = 1'b0;
`endif

  // State and byte-counter register.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_reg     <= S_HDR;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
    end
  end

  // Next-state logic; a burst end on a header/CRC word is a normal finish.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HDR: begin
        if (word_in) begin
          if (!strb_ok || ecc_fatal) state_next = last_in ? S_HDR : S_DISCARD;
          else if (long_w && !last_in) state_next = wc_zero ? S_CRC : S_PAY;
        end
      end
      S_PAY: begin
        if (last_in)                  state_next = S_HDR;
        else if (word_in && pay_last_w) state_next = S_CRC;
      end
      S_CRC: begin
        if (word_in) state_next = S_HDR;
      end
      S_DISCARD: begin
        if (last_in) state_next = S_HDR;
      end
      default: state_next = S_HDR;
    endcase
  end

  // Output decode: header fields, payload word, pulses and error counters.
  always_comb begin
    remaining_next     = remaining_reg;
    hdr_valid_next     = 1'b0;
    hdr_vc_next        = hdr_vc_reg;
    hdr_dt_next        = hdr_dt_reg;
    hdr_wc_next        = hdr_wc_reg;
    hdr_long_next      = hdr_long_reg;
    payload_data_next  = '0;
    payload_strb_next  = '0;
    payload_valid_next = 1'b0;
    payload_last_next  = 1'b0;
    pkt_done_next      = 1'b0;
    ecc_corr_next      = 1'b0;
    ecc_fatal_next     = 1'b0;
    crc_err_next       = 1'b0;
    trunc_next         = 1'b0;
    case (state_reg)
      S_HDR: begin
        if (word_in) begin
          if (!strb_ok) begin
            trunc_next = 1'b1;
          end else if (ecc_fatal) begin
            ecc_fatal_next = 1'b1;
          end else begin
            hdr_valid_next = 1'b1;
            hdr_vc_next    = hdr_fixed[23:22];
            hdr_dt_next    = hdr_fixed[21:16];
            hdr_wc_next    = hdr_fixed[15:0];
            hdr_long_next  = long_w;
            ecc_corr_next  = ecc_corr;
            if (long_w) begin
              remaining_next = WC_WIDTH'(hdr_fixed[15:0]);
              trunc_next     = last_in;
            end else begin
              pkt_done_next = 1'b1;
            end
          end
        end
      end
      S_PAY: begin
        if (word_in) begin
          payload_valid_next = 1'b1;
          payload_data_next  = pay_data_w;
          payload_strb_next  = take_strb;
          payload_last_next  = pay_last_w;
          remaining_next     = remaining_reg - WC_WIDTH'(take_bytes);
          trunc_next         = last_in;
        end
      end
      S_CRC: begin
        if (word_in) begin
          pkt_done_next = 1'b1;
          crc_err_next  = crc_mismatch;
        end
      end
      default: ;
    endcase

    cnt_ecc_next = cnt_ecc_reg;
    if ((ecc_corr_next || ecc_fatal_next) && (cnt_ecc_reg != '1))
      cnt_ecc_next = cnt_ecc_reg + 1'b1;
    cnt_crc_next = cnt_crc_reg;
    if (crc_err_next && (cnt_crc_reg != '1))
      cnt_crc_next = cnt_crc_reg + 1'b1;
  end

  // Registered outputs; everything clears on reset.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      hdr_valid_reg     <= 1'b0;
      hdr_vc_reg        <= '0;
      hdr_dt_reg        <= '0;
      hdr_wc_reg        <= '0;
      hdr_long_reg      <= 1'b0;
      payload_data_reg  <= '0;
      payload_strb_reg  <= '0;
      payload_valid_reg <= 1'b0;
      payload_last_reg  <= 1'b0;
      pkt_done_reg      <= 1'b0;
      ecc_corr_reg      <= 1'b0;
      ecc_fatal_reg     <= 1'b0;
      crc_err_reg       <= 1'b0;
      trunc_reg         <= 1'b0;
      cnt_ecc_reg       <= '0;
      cnt_crc_reg       <= '0;
    end else begin
      hdr_valid_reg     <= hdr_valid_next;
      hdr_vc_reg        <= hdr_vc_next;
      hdr_dt_reg        <= hdr_dt_next;
      hdr_wc_reg        <= hdr_wc_next;
      hdr_long_reg      <= hdr_long_next;
      payload_data_reg  <= payload_data_next;
      payload_strb_reg  <= payload_strb_next;
      payload_valid_reg <= payload_valid_next;
      payload_last_reg  <= payload_last_next;
      pkt_done_reg      <= pkt_done_next;
      ecc_corr_reg      <= ecc_corr_next;
      ecc_fatal_reg     <= ecc_fatal_next;
      crc_err_reg       <= crc_err_next;
      trunc_reg         <= trunc_next;
      cnt_ecc_reg       <= cnt_ecc_next;
      cnt_crc_reg       <= cnt_crc_next;
    end
  end

  assign hdr_valid         = hdr_valid_reg;
  assign hdr_vc            = hdr_vc_reg;
  assign hdr_dt            = hdr_dt_reg;
  assign hdr_wc            = hdr_wc_reg;
  assign hdr_long          = hdr_long_reg;
  assign payload_data      = payload_data_reg;
  assign payload_strb      = payload_strb_reg;
  assign payload_valid     = payload_valid_reg;
  assign payload_last      = payload_last_reg;
  assign pkt_done          = pkt_done_reg;
  assign err_ecc_corrected = ecc_corr_reg;
  assign err_ecc_fatal     = ecc_fatal_reg;
  assign err_crc           = crc_err_reg;
  assign err_truncated     = trunc_reg;
  assign err_cnt_ecc       = cnt_ecc_reg;
  assign err_cnt_crc       = cnt_crc_reg;

endmodule

// File: tb/tb_packets_parser.sv
// Scoreboard bench for packets_parser: stimulus pushes expected headers,
// payload words and packet completions; a monitor pops them on DUT outputs.
module tb_packets_parser;

`ifdef DSI_PARSER_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst_sys = 1'b1;
  always #5 clk_sys = ~clk_sys;

  packets_parser_if rxif ();

  logic        hdr_valid, hdr_long, payload_valid, payload_last, pkt_done;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [31:0] payload_data;
  logic [3:0]  payload_strb;
  logic        err_ecc_corrected, err_ecc_fatal, err_crc, err_truncated;
  logic [7:0]  err_cnt_ecc, err_cnt_crc;

  packets_parser #(.WC_WIDTH(16), .ERR_CNT_WIDTH(8)) dut (
    .clk_sys           (clk_sys),
    .rst_sys           (rst_sys),
    .rx                (rxif),
    .hdr_valid         (hdr_valid),
    .hdr_vc            (hdr_vc),
    .hdr_dt            (hdr_dt),
    .hdr_wc            (hdr_wc),
    .hdr_long          (hdr_long),
    .payload_data      (payload_data),
    .payload_strb      (payload_strb),
    .payload_valid     (payload_valid),
    .payload_last      (payload_last),
    .pkt_done          (pkt_done),
    .err_ecc_corrected (err_ecc_corrected),
    .err_ecc_fatal     (err_ecc_fatal),
    .err_crc           (err_crc),
    .err_truncated     (err_truncated),
    .err_cnt_ecc       (err_cnt_ecc),
    .err_cnt_crc       (err_cnt_crc)
  );

  typedef struct {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        lng;
    logic        done;
    logic        corr;
  } hdr_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } pay_exp_t;

  hdr_exp_t hdr_q[$];
  pay_exp_t pay_q[$];
  logic     done_q[$];   // expected err_crc value at each long-packet pkt_done

  int check_count = 0;
  int pass_count  = 0;
  int obs_fatal = 0, obs_trunc = 0;
  int exp_fatal = 0, exp_trunc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // DSI header ECC written out as the parity equations over header bits [31:8].
  function automatic logic [7:0] ecc8(input logic [23:0] d);
    logic [7:0] p;
    p    = '0;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [7:0] di, input logic [15:0] wc);
    return {di, wc, ecc8({di, wc})};
  endfunction

  // Reflected CCITT CRC, byte-at-a-time form.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic last);
    @(negedge clk_sys);
    rxif.iface_read_data  = d;
    rxif.iface_read_strb  = s;
    rxif.iface_read_valid = 1'b1;
    rxif.iface_last_word  = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      rxif.iface_read_valid = 1'b0;
      rxif.iface_last_word  = 1'b0;
      rxif.iface_read_data  = '0;
      rxif.iface_read_strb  = '0;
    end
  endtask

  task automatic exp_hdr(input logic [7:0] di, input logic [15:0] wc, input logic lng,
                         input logic corr);
    hdr_exp_t h;
    h.vc = di[7:6]; h.dt = di[5:0]; h.wc = wc; h.lng = lng; h.done = !lng; h.corr = corr;
    hdr_q.push_back(h);
  endtask

  task automatic exp_pay(input logic [31:0] d, input logic [3:0] s, input logic last);
    pay_exp_t p;
    p.data = d; p.strb = s; p.last = last;
    pay_q.push_back(p);
  endtask

  // Monitor: compares every DUT output event against the scoreboard.
  always @(negedge clk_sys) begin
    hdr_exp_t h;
    pay_exp_t p;
    logic     ce;
    if (hdr_valid) begin
      if (hdr_q.size() > 0) begin
        h = hdr_q.pop_front();
        check("hdr_vc", 32'(hdr_vc), 32'(h.vc));
        check("hdr_dt", 32'(hdr_dt), 32'(h.dt));
        check("hdr_wc", 32'(hdr_wc), 32'(h.wc));
        check("hdr_long", 32'(hdr_long), 32'(h.lng));
        check("hdr_pkt_done", 32'(pkt_done), 32'(h.done));
        check("hdr_ecc_corrected", 32'(err_ecc_corrected), 32'(h.corr));
        $display("hdr   vc=%0d dt=0x%02h wc=0x%04h long=%0b", hdr_vc, hdr_dt, hdr_wc, hdr_long);
      end else begin
        check("hdr_unexpected", 32'(hdr_valid), 32'd0);
      end
    end else begin
      if (err_ecc_corrected) check("ecc_corrected_stray", 32'(err_ecc_corrected), 32'd0);
      if (pkt_done) begin
        if (done_q.size() > 0) begin
          ce = done_q.pop_front();
          check("done_no_payload", 32'(payload_valid), 32'd0);
          check("done_err_crc", 32'(err_crc), 32'(ce));
          $display("done  err_crc=%0b", err_crc);
        end else begin
          check("pkt_done_unexpected", 32'(pkt_done), 32'd0);
        end
      end
    end
    if (err_crc && !(pkt_done && !hdr_valid)) check("err_crc_stray", 32'(err_crc), 32'd0);
    if (payload_valid) begin
      if (pay_q.size() > 0) begin
        p = pay_q.pop_front();
        check("payload_data", payload_data, p.data);
        check("payload_strb", 32'(payload_strb), 32'(p.strb));
        check("payload_last", 32'(payload_last), 32'(p.last));
        $display("pay   data=0x%08h strb=0x%h last=%0b", payload_data, payload_strb, payload_last);
      end else begin
        check("payload_unexpected", 32'(payload_valid), 32'd0);
      end
    end
    if (err_ecc_fatal) obs_fatal++;
    if (err_truncated) obs_trunc++;
  end

  initial begin
    logic [15:0] c;
    rxif.iface_read_data  = '0;
    rxif.iface_read_strb  = '0;
    rxif.iface_read_valid = 1'b0;
    rxif.iface_last_word  = 1'b0;

    // Reset state.
    idle(3);
    check("reset_pulses", {24'h0, hdr_valid, payload_valid, payload_last, pkt_done,
                           err_ecc_corrected, err_ecc_fatal, err_crc, err_truncated}, 32'h0);
    check("reset_cnt", {16'h0, err_cnt_ecc, err_cnt_crc}, 32'h0);
    rst_sys = 1'b0;
    idle(2);

    // Short DCS packet, one-word burst.
    exp_hdr(8'h05, 16'h3611, 1'b0, 1'b0);
    send(mk_hdr(8'h05, 16'h3611), 4'hF, 1'b1);
    idle(2);

    // Long DCS packet WC=6 with a good CRC and an idle gap inside the payload.
    c = 16'hFFFF;
    for (int i = 1; i <= 6; i++) c = crc_upd(c, 8'(i));
    exp_hdr(8'h39, 16'd6, 1'b1, 1'b0);
    exp_pay(32'h04030201, 4'hF, 1'b0);
    exp_pay(32'h00000605, 4'h3, 1'b1);
    done_q.push_back(1'b0);
    send(mk_hdr(8'h39, 16'd6), 4'hF, 1'b0);
    send(32'h04030201, 4'hF, 1'b0);
    idle(1);
    send(32'h00000605, 4'h3, 1'b0);
    send({16'h0000, c}, 4'hF, 1'b1);
    idle(2);

    // Single-bit header error (bit 12) is corrected.
    exp_hdr(8'h45, 16'h1234, 1'b0, 1'b1);
    send(mk_hdr(8'h45, 16'h1234) ^ 32'h0000_1000, 4'hF, 1'b1);
    idle(2);
    check("cnt_ecc_after_corr", 32'(err_cnt_ecc), 32'd1);

    // Double-bit error: fatal, the rest of the burst (valid-looking headers) dropped.
    exp_fatal++;
    send(mk_hdr(8'h05, 16'h0001) ^ 32'h0010_1000, 4'hF, 1'b0);
    send(mk_hdr(8'h05, 16'h7777), 4'hF, 1'b0);
    send(mk_hdr(8'h15, 16'h0102), 4'hF, 1'b1);
    idle(2);
    check("cnt_ecc_after_fatal", 32'(err_cnt_ecc), 32'd2);

    // Long RGB888 packet WC=8 with a corrupted CRC word.
    c = 16'hFFFF;
    c = crc_upd(c, 8'hAA); c = crc_upd(c, 8'hBB); c = crc_upd(c, 8'hCC); c = crc_upd(c, 8'hDD);
    c = crc_upd(c, 8'h11); c = crc_upd(c, 8'h22); c = crc_upd(c, 8'h33); c = crc_upd(c, 8'h44);
    exp_hdr(8'h3E, 16'd8, 1'b1, 1'b0);
    exp_pay(32'hDDCCBBAA, 4'hF, 1'b0);
    exp_pay(32'h44332211, 4'hF, 1'b1);
    done_q.push_back(CRC_EN);
    send(mk_hdr(8'h3E, 16'd8), 4'hF, 1'b0);
    send(32'hDDCCBBAA, 4'hF, 1'b0);
    send(32'h44332211, 4'hF, 1'b0);
    send({16'hA5A5, c ^ 16'h0001}, 4'hF, 1'b1);
    idle(2);
    check("cnt_crc_after_bad_crc", 32'(err_cnt_crc), CRC_EN ? 32'd1 : 32'd0);

    // Burst ends on the 2nd payload word of WC=12: truncated, no pkt_done.
    exp_trunc++;
    exp_hdr(8'h39, 16'd12, 1'b1, 1'b0);
    exp_pay(32'h44332211, 4'hF, 1'b0);
    exp_pay(32'h88776655, 4'hF, 1'b0);
    send(mk_hdr(8'h39, 16'd12), 4'hF, 1'b0);
    send(32'h44332211, 4'hF, 1'b0);
    send(32'h88776655, 4'hF, 1'b1);
    idle(1);
    exp_hdr(8'h01, 16'h0000, 1'b0, 1'b0);
    send(mk_hdr(8'h01, 16'h0000), 4'hF, 1'b1);
    idle(2);

    // Header with a partial strobe: truncated, remainder of burst discarded.
    exp_trunc++;
    send(mk_hdr(8'h05, 16'h5555), 4'h7, 1'b0);
    send(mk_hdr(8'h05, 16'h6666), 4'hF, 1'b1);
    idle(2);

    // Reset while in the payload phase.
    exp_hdr(8'h39, 16'd12, 1'b1, 1'b0);
    exp_pay(32'h0D0C0B0A, 4'hF, 1'b0);
    send(mk_hdr(8'h39, 16'd12), 4'hF, 1'b0);
    send(32'h0D0C0B0A, 4'hF, 1'b0);
    @(negedge clk_sys);
    rst_sys = 1'b1;
    rxif.iface_read_valid = 1'b0;
    rxif.iface_last_word  = 1'b0;
    @(negedge clk_sys);
    check("midrst_pulses", {24'h0, hdr_valid, payload_valid, payload_last, pkt_done,
                            err_ecc_corrected, err_ecc_fatal, err_crc, err_truncated}, 32'h0);
    check("midrst_cnt", {16'h0, err_cnt_ecc, err_cnt_crc}, 32'h0);
    check("midrst_payload_data", payload_data, 32'h0);
    rst_sys = 1'b0;
    idle(1);

    // Short HSS packet parses normally after reset.
    exp_hdr(8'h21, 16'h00AB, 1'b0, 1'b0);
    send(mk_hdr(8'h21, 16'h00AB), 4'hF, 1'b1);
    idle(1);

    // Zero-length long packet: header, CRC word of an empty payload, pkt_done.
    exp_hdr(8'h19, 16'd0, 1'b1, 1'b0);
    done_q.push_back(1'b0);
    send(mk_hdr(8'h19, 16'd0), 4'hF, 1'b0);
    send(32'h0000FFFF, 4'hF, 1'b1);
    idle(4);

    check("hdr_all_seen", 32'(hdr_q.size()), 32'd0);
    check("pay_all_seen", 32'(pay_q.size()), 32'd0);
    check("done_all_seen", 32'(done_q.size()), 32'd0);
    check("fatal_pulses", 32'(obs_fatal), 32'(exp_fatal));
    check("trunc_pulses", 32'(obs_trunc), 32'(exp_trunc));
    check("final_cnt_ecc", 32'(err_cnt_ecc), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/packets_parser.md
Name: packets_parser

Overview:
- Receive-side counterpart of the DSI packet assembler.
- Takes the 32-bit word stream delivered by the lanes receiver for each HS burst and splits it into DSI packets.
- Checks and corrects each header with ECC, verifies the long-packet CRC, and emits the header fields plus a payload word stream to downstream command and pixel sinks.
- Used in the loopback/verification path and in the read-back (BTA response) path.

Parameters:
- WC_WIDTH, 16, width of the word-count field and the byte counter.
- ERR_CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_sys  in  1  synchronous, active-high reset.
- iface_read_data  in  32  received word; byte0 = bits[7:0].
- iface_read_strb  in  4  valid-byte mask for iface_read_data.
- iface_read_valid  in  1  word present this cycle; no backpressure.
- iface_last_word  in  1  qualifies the final word of the current HS burst.
- hdr_valid  out  1  one-cycle pulse; all hdr_* fields valid.
- hdr_vc  out  2  virtual channel, DI[7:6].
- hdr_dt  out  6  data type, DI[5:0].
- hdr_wc  out  16  word count (long packet) or data0/data1 (short packet), after correction.
- hdr_long  out  1  1 when the packet is a long packet.
- payload_data  out  32  payload word.
- payload_strb  out  4  valid bytes in payload_data.
- payload_valid  out  1  payload word valid.
- payload_last  out  1  marks the last payload word.
- pkt_done  out  1  one-cycle pulse at the end of each accepted packet.
- err_ecc_corrected  out  1  pulse: single-bit header error was corrected.
- err_ecc_fatal  out  1  pulse: header error is uncorrectable.
- err_crc  out  1  pulse: CRC mismatch.
- err_truncated  out  1  pulse: burst ended mid-packet, or a bad strobe was seen.
- err_cnt_ecc, err_cnt_crc  out  ERR_CNT_WIDTH each  saturating counters.

Behaviour:
- Header word format:
  - [31:24] DI
  - [23:8] WC / short data
  - [7:0] ECC
  - ECC covers [31:8] (DSI Hamming SEC-DED, ECC[7:6] = 0).
- Every burst starts word-aligned with a header word.
- Payload bytes follow packed little-endian. The last payload word is zero-padded.
- CRC occupies its own word in bits[15:0], bits[31:16] ignored. The next header starts on the following word.
- FSM states and transitions:
  - S_HDR: waits for a valid word.
    - Syndrome zero, or single-bit error (corrected): register the fields, then go to S_PAY, or to S_CRC when hdr_long and WC = 0. A short packet stays in S_HDR.
    - Uncorrectable error: go to S_DISCARD.
  - S_PAY: byte counter loads WC and decrements by min(4, remaining) per valid word. payload_last is set when remaining ≤ 4; go to S_CRC.
  - S_CRC: compare against the CRC computed over the payload bytes (init 0xFFFF, CCITT, LSB first). Pulse err_crc on mismatch, pulse pkt_done, go to S_HDR.
  - S_DISCARD: drop words until iface_last_word, then go to S_HDR.
- iface_last_word seen in S_PAY or S_CRC before the packet completes: pulse err_truncated, go to S_HDR without pkt_done.
- iface_last_word on a header or CRC word completes the packet normally.
- Header word with iface_read_strb != 4'hF: treated as err_truncated, go to S_DISCARD.
- Long data types are the package list {0x09,0x19,0x29,0x39,0x0C,0x1C,0x2C,0x0D,0x1D,0x3D,0x0E,0x1E,0x2E,0x3E}. All other DTs are short.
- Latency: hdr_valid, payload_*, and error pulses are registered, 1 cycle after the input word. pkt_done comes 1 cycle after the CRC word (long) or coincides with hdr_valid (short).
- Idle cycles (iface_read_valid = 0) inside a packet are allowed; state holds.
- Reset, including mid-packet: state S_HDR, all outputs and pulses 0, counters 0, CRC reinitialised.
- Error counters saturate at all-ones.
- If err_ecc_corrected and err_crc occur in the same packet, both pulse and both counters increment.

Optional Feature:
- Macro DSI_PARSER_CRC_CHECK_EN.
- Defined: a CRC engine is instantiated and err_crc / err_cnt_crc are active.
- Undefined: the CRC word is consumed and ignored, err_crc is tied to 0, err_cnt_crc stays at 0, and the CRC logic is absent.

Decomposition:
- Package dsi_pkg holds:
  - DT constants (VSS 0x01, HSS 0x21, blank 0x19, RGB888 0x3E, DCS short 0x05/0x15, DCS long 0x39)
  - the is_long_dt function
  - the FSM state enum
  - the ECC parity masks
- Sub-module ecc_decoder (combinational), shared with the assembler's ECC masks. It takes the 32-bit header word and outputs:
  - the corrected 24 bits
  - a corrected flag
  - a fatal flag
- CRC reuses the existing crc_calculator.

Test Plan:
- Short packet, DI = 0x05, data 0x3611 with correct ECC -> hdr_valid, dt = 0x05, wc = 0x3611, hdr_long = 0, pkt_done in the same cycle, no errors.
- Long 0x39 packet, WC = 6, payload 01..06, valid CRC -> two payload words:
  - first: strb F
  - second: strb 3, payload_last
  - then pkt_done, err_crc = 0.
- Header with bit 12 flipped -> err_ecc_corrected pulse, hdr_wc restored, err_cnt_ecc = 1. With two bits flipped -> err_ecc_fatal, words discarded until iface_last_word.
- Long packet WC = 8 with the CRC word corrupted -> err_crc pulse, err_cnt_crc = 1. With the macro undefined -> no pulse.
- iface_last_word on the 2nd payload word of WC = 12 -> err_truncated, no pkt_done; the next burst's header parses correctly.
- Reset asserted in S_PAY -> all outputs 0 next cycle; a following short packet parses normally; WC = 0 long packet -> hdr_valid then CRC word then pkt_done.
